// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use / redirect hazard detection, ecall halt sequencing and perf counters
module hazard_unit #(
    parameter int REG_IDX_W = 5,
    parameter int LD_LAT    = 1,
    parameter int DRAIN     = 3,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_rs1_index,
    input  logic [REG_IDX_W-1:0] id_rs2_index,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic                 id_ecall,
    input  logic                 ex_valid,
    input  logic                 ex_wb_en,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_rd_index,
    input  logic                 ex_branch_taken,
    output logic                 stall_pc,
    output logic                 stall_if_id,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 halt,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    // At least one slot is declared so the arrays stay legal when LD_LAT=1;
    // that slot is then held invalid.
    localparam int SB_N = (LD_LAT > 1) ? LD_LAT - 1 : 1;
    localparam logic [2:0]       DRAIN_INIT = 3'(DRAIN);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

    state_t                           state_q, state_d;
    logic [2:0]                       drain_q, drain_d;
    logic [SB_N-1:0]                  sb_valid;
    logic [SB_N-1:0][REG_IDX_W-1:0]   sb_rd;
    logic                             ex_ld_q;
    logic                             load_use;
    logic                             ecall_go;

    assign ex_ld_q = ex_valid & ex_is_load & ex_wb_en & (ex_rd_index != '0);

    generate
        if (LD_LAT > 1) begin : g_sb
            // Scoreboard of in-flight loads past EX; shifts every cycle, bubbles enter when EX holds no load
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sb_valid <= '0;
                    sb_rd    <= '0;
                end else begin
                    sb_valid[0] <= ex_ld_q;
                    sb_rd[0]    <= ex_rd_index;
                    for (int k = 1; k < SB_N; k++) begin
                        sb_valid[k] <= sb_valid[k-1];
                        sb_rd[k]    <= sb_rd[k-1];
                    end
                end
            end
        end else begin : g_no_sb
            assign sb_valid = '0;
            assign sb_rd    = '0;
        end
    endgenerate

    function automatic logic src_hit(input logic [REG_IDX_W-1:0] idx);
        logic hit;
        hit = ex_ld_q && (ex_rd_index == idx);
        for (int k = 0; k < SB_N; k++) begin
            if (sb_valid[k] && (sb_rd[k] == idx)) hit = 1'b1;
        end
        return hit && (idx != '0);
    endfunction

    // Load-use detection against the load in EX and every pending scoreboard entry
    always_comb begin
        load_use = id_valid &
                   ((id_rs1_used & src_hit(id_rs1_index)) |
                    (id_rs2_used & src_hit(id_rs2_index)));
        ecall_go = id_valid & id_ecall & ~ex_branch_taken & ~load_use;
    end

    // Halt FSM state and drain counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Halt FSM next state: ecall starts a fixed-length drain, then the core stays halted
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            ST_RUN: begin
                if (ecall_go) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_INIT;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - 3'd1;
                if (drain_q == 3'd1) state_d = ST_HALTED;
            end
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_RUN;
        endcase
    end

    // Pipeline control outputs; a redirect wins over a load-use stall while running
    always_comb begin
        stall_pc    = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        halt        = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (ex_branch_taken) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (load_use) begin
                    stall_pc    = 1'b1;
                    stall_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
            ST_DRAIN: begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            ST_HALTED: begin
                stall_pc    = 1'b1;
                stall_if_id = 1'b1;
                flush_id_ex = 1'b1;
                halt        = 1'b1;
            end
            default: ;
        endcase
    end

    // Saturating stall-cycle and redirect counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;
            if ((state_q == ST_RUN) && ex_branch_taken && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit (LD_LAT=1/CNT_W=32 and LD_LAT=3/CNT_W=4 instances)
module tb_hazard_unit;

    localparam int DRAIN_N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       id_valid, id_rs1_used, id_rs2_used, id_ecall;
    logic [4:0] id_rs1_index, id_rs2_index, ex_rd_index;
    logic       ex_valid, ex_wb_en, ex_is_load, ex_branch_taken;

    logic        a_sp, a_si, a_fp, a_fe, a_halt;
    logic [31:0] a_sc, a_fc;
    logic        b_sp, b_si, b_fp, b_fe, b_halt;
    logic [3:0]  b_sc, b_fc;

    hazard_unit #(.REG_IDX_W(5), .LD_LAT(1), .DRAIN(DRAIN_N), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_index(id_rs1_index),
        .id_rs2_index(id_rs2_index), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_ecall(id_ecall), .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
        .ex_rd_index(ex_rd_index), .ex_branch_taken(ex_branch_taken),
        .stall_pc(a_sp), .stall_if_id(a_si), .flush_if_id(a_fp), .flush_id_ex(a_fe),
        .halt(a_halt), .stall_cnt(a_sc), .flush_cnt(a_fc)
    );

    hazard_unit #(.REG_IDX_W(5), .LD_LAT(3), .DRAIN(DRAIN_N), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_index(id_rs1_index),
        .id_rs2_index(id_rs2_index), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_ecall(id_ecall), .ex_valid(ex_valid), .ex_wb_en(ex_wb_en), .ex_is_load(ex_is_load),
        .ex_rd_index(ex_rd_index), .ex_branch_taken(ex_branch_taken),
        .stall_pc(b_sp), .stall_if_id(b_si), .flush_if_id(b_fp), .flush_id_ex(b_fe),
        .halt(b_halt), .stall_cnt(b_sc), .flush_cnt(b_fc)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: history of qualifying load destinations plus the cycle an ecall was accepted
    int     lat[2]  = '{1, 3};
    longint cmax[2] = '{64'hFFFF_FFFF, 15};
    int     hist[2][3];
    int     ec[2];
    longint m_sc[2], m_fc[2];
    int     cyc = 0;
    logic   e_sp, e_fp, e_fe, e_halt, e_hz, e_run;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 3; k++) hist[d][k] = 0;
            ec[d]   = -1;
            m_sc[d] = 0;
            m_fc[d] = 0;
        end
    endtask

    function automatic bit m_hit(int d, int idx, int exq);
        if (idx == 0) return 0;
        if (exq == idx) return 1;
        for (int k = 0; k < lat[d] - 1; k++) if (hist[d][k] == idx) return 1;
        return 0;
    endfunction

    task automatic model_eval(input int d);
        int exq;
        exq   = (ex_valid && ex_wb_en && ex_is_load) ? int'(ex_rd_index) : 0;
        e_hz  = id_valid && ((id_rs1_used && m_hit(d, int'(id_rs1_index), exq)) ||
                             (id_rs2_used && m_hit(d, int'(id_rs2_index), exq)));
        e_run = (ec[d] < 0);
        e_halt = !e_run && (cyc - ec[d] > DRAIN_N);
        if (e_run) begin
            e_sp = ex_branch_taken ? 1'b0 : e_hz;
            e_fp = ex_branch_taken;
            e_fe = ex_branch_taken | e_hz;
        end else begin
            e_sp = 1'b1;
            e_fp = 1'b0;
            e_fe = 1'b1;
        end
    endtask

    task automatic model_adv();
        for (int d = 0; d < 2; d++) begin
            model_eval(d);
            if (e_sp && m_sc[d] < cmax[d]) m_sc[d]++;
            if (e_run && ex_branch_taken && m_fc[d] < cmax[d]) m_fc[d]++;
            if (e_run && id_valid && id_ecall && !ex_branch_taken && !e_hz) ec[d] = cyc;
            hist[d][2] = hist[d][1];
            hist[d][1] = hist[d][0];
            hist[d][0] = (ex_valid && ex_wb_en && ex_is_load) ? int'(ex_rd_index) : 0;
        end
        cyc++;
    endtask

    // Called at a falling edge with inputs applied; compares both instances against the model
    task automatic settle();
        #1;
        for (int d = 0; d < 2; d++) begin
            model_eval(d);
            chk(d == 0 ? "a_stall_pc"    : "b_stall_pc",    d == 0 ? a_sp : b_sp, e_sp);
            chk(d == 0 ? "a_stall_if_id" : "b_stall_if_id", d == 0 ? a_si : b_si, e_sp);
            chk(d == 0 ? "a_flush_if_id" : "b_flush_if_id", d == 0 ? a_fp : b_fp, e_fp);
            chk(d == 0 ? "a_flush_id_ex" : "b_flush_id_ex", d == 0 ? a_fe : b_fe, e_fe);
            chk(d == 0 ? "a_halt"        : "b_halt",        d == 0 ? a_halt : b_halt, e_halt);
            chk(d == 0 ? "a_stall_cnt"   : "b_stall_cnt",   d == 0 ? a_sc : 64'(b_sc), m_sc[d]);
            chk(d == 0 ? "a_flush_cnt"   : "b_flush_cnt",   d == 0 ? a_fc : 64'(b_fc), m_fc[d]);
        end
    endtask

    task automatic advance();
        model_adv();
        @(negedge clk);
    endtask

    task automatic set_idle();
        id_valid = 0; id_rs1_index = 0; id_rs2_index = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_ecall = 0; ex_valid = 0; ex_wb_en = 0; ex_is_load = 0; ex_rd_index = 0;
        ex_branch_taken = 0;
    endtask

    task automatic set_ld(input logic [4:0] rd);
        ex_valid = 1; ex_wb_en = 1; ex_is_load = 1; ex_rd_index = rd;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 0;
        #1;
        model_reset();
        chk("rst_halt", a_halt, 0);
        chk("rst_stall_cnt", a_sc, 0);
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    typedef struct {
        logic idv; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic exv; logic exw; logic exl; logic [4:0] exrd; logic br;
        logic sp; logic fp; logic fe;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // LD_LAT=1 expectations, applied in order from reset
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 5, 1, 0, 0, 1, 1, 1, 5, 0, 1, 0, 1};
        tbl[2]  = '{1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[4]  = '{1, 1, 1, 9, 1, 1, 1, 1, 9, 0, 1, 0, 1};
        tbl[5]  = '{1, 1, 1, 9, 0, 1, 1, 1, 9, 0, 0, 0, 0};
        tbl[6]  = '{1, 9, 1, 0, 0, 1, 0, 1, 9, 0, 0, 0, 0};
        tbl[7]  = '{0, 9, 1, 0, 0, 1, 1, 1, 9, 0, 0, 0, 0};
        tbl[8]  = '{1, 3, 1, 0, 0, 1, 1, 1, 3, 1, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
        tbl[10] = '{1, 9, 1, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0};

        set_idle();
        rst = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Table vectors
        foreach (tbl[i]) begin
            id_valid = tbl[i].idv; id_rs1_index = tbl[i].rs1; id_rs1_used = tbl[i].u1;
            id_rs2_index = tbl[i].rs2; id_rs2_used = tbl[i].u2; id_ecall = 0;
            ex_valid = tbl[i].exv; ex_wb_en = tbl[i].exw; ex_is_load = tbl[i].exl;
            ex_rd_index = tbl[i].exrd; ex_branch_taken = tbl[i].br;
            settle();
            chk($sformatf("tbl%0d_sp", i), a_sp, tbl[i].sp);
            chk($sformatf("tbl%0d_si", i), a_si, tbl[i].sp);
            chk($sformatf("tbl%0d_fp", i), a_fp, tbl[i].fp);
            chk($sformatf("tbl%0d_fe", i), a_fe, tbl[i].fe);
            advance();
        end
        set_idle();
        settle();
        chk("tbl_stall_cnt", a_sc, 2);
        chk("tbl_flush_cnt", a_fc, 2);

        // Load-use and redirect together
        do_reset();
        set_ld(5'd4); id_valid = 1; id_rs1_index = 4; id_rs1_used = 1; ex_branch_taken = 1;
        settle();
        chk("lu_br_sp", a_sp, 0);
        chk("lu_br_fp", a_fp, 1);
        advance();
        set_idle();
        settle();
        chk("lu_br_stall_cnt", a_sc, 0);
        chk("lu_br_flush_cnt", a_fc, 1);

        // LD_LAT=3 stalls for three consecutive cycles
        do_reset();
        set_ld(5'd7); id_valid = 1; id_rs1_index = 7; id_rs1_used = 1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk($sformatf("lat3_c%0d", i), b_sp, (i < 3));
            advance();
            ex_valid = 0; ex_wb_en = 0; ex_is_load = 0; ex_rd_index = 0;
        end

        // Ecall: three drain cycles, then sticky halt; reset in HALTED drops halt at once
        do_reset();
        id_valid = 1; id_ecall = 1;
        settle();
        chk("ecall_run_sp", a_sp, 0);
        advance();
        set_idle();
        for (int i = 0; i < DRAIN_N; i++) begin
            ex_branch_taken = (i == 1);
            settle();
            chk($sformatf("drain%0d_sp", i), a_sp, 1);
            chk($sformatf("drain%0d_halt", i), a_halt, 0);
            chk($sformatf("drain%0d_fp", i), a_fp, 0);
            advance();
        end
        ex_branch_taken = 0;
        for (int i = 0; i < 100; i++) begin
            settle();
            chk("halted_halt", a_halt, 1);
            advance();
        end
        settle();
        #2 rst = 0;
        #1;
        chk("async_rst_halted_a", a_halt, 0);
        chk("async_rst_halted_b", b_halt, 0);
        @(negedge clk);
        model_reset();
        rst = 1;

        // Reset mid-drain returns to RUN immediately
        id_valid = 1; id_ecall = 1;
        settle();
        advance();
        set_idle();
        settle();
        chk("mid_drain_sp", a_sp, 1);
        #2 rst = 0;
        #1;
        chk("async_rst_drain_sp", a_sp, 0);
        chk("async_rst_drain_fe", a_fe, 0);
        chk("async_rst_drain_halt", a_halt, 0);
        @(negedge clk);
        model_reset();
        rst = 1;

        // 20 stall cycles saturate the 4-bit counter
        set_ld(5'd7); id_valid = 1; id_rs1_index = 7; id_rs1_used = 1;
        repeat (20) begin
            settle();
            advance();
        end
        set_idle();
        settle();
        chk("sat_b_stall_cnt", 64'(b_sc), 15);
        chk("sat_a_stall_cnt", a_sc, 20);

        // Randomized segments against the model
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int i = 0; i < 80; i++) begin
                id_valid        = ($urandom_range(0, 3) != 0);
                id_rs1_index    = 5'($urandom_range(0, 7));
                id_rs2_index    = 5'($urandom_range(0, 7));
                id_rs1_used     = 1'($urandom_range(0, 1));
                id_rs2_used     = 1'($urandom_range(0, 1));
                id_ecall        = ($urandom_range(0, 39) == 0);
                ex_valid        = ($urandom_range(0, 3) != 0);
                ex_wb_en        = ($urandom_range(0, 3) != 0);
                ex_is_load      = 1'($urandom_range(0, 1));
                ex_rd_index     = 5'($urandom_range(0, 7));
                ex_branch_taken = ($urandom_range(0, 5) == 0);
                settle();
                advance();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter REG_IDX_W, default 5: register index width.
REQ-002 Parameter LD_LAT, default 1, legal range 1..3: cycles after EX until load data can be forwarded.
REQ-003 Parameter DRAIN, default 3, legal range 1..7: cycles the halt FSM drains before asserting halt.
REQ-004 Parameter CNT_W, default 32: performance counter width.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 id_valid  in  1  ID stage holds a valid instruction.
REQ-008 id_rs1_index, id_rs2_index  in  REG_IDX_W  ID source indices.
REQ-009 id_rs1_used, id_rs2_used  in  1  ID instruction actually reads rs1/rs2.
REQ-010 id_ecall  in  1  ID instruction is ecall.
REQ-011 ex_valid, ex_wb_en, ex_is_load  in  1  EX valid, writes back, is a load.
REQ-012 ex_rd_index  in  REG_IDX_W  EX destination index.
REQ-013 ex_branch_taken  in  1  EX redirects the PC (taken branch or jump).
REQ-014 stall_pc, stall_if_id  out  1  hold PC and IF/ID register.
REQ-015 flush_if_id, flush_id_ex  out  1  squash IF/ID / insert bubble into ID/EX.
REQ-016 halt  out  1  core halted; sticky.
REQ-017 stall_cnt, flush_cnt  out  CNT_W  stall-cycle and redirect counters.

Function
REQ-018 Scoreboard: LD_LAT-1 entries of {valid, rd} (none when LD_LAT=1); entry 0 captures EX when ex_valid & ex_is_load & ex_wb_en & ex_rd_index!=0, else valid=0; entry k takes entry k-1 each cycle; last entry shifts out.
REQ-019 Scoreboard shifts every cycle regardless of stalls; a bubble enters entry 0 when EX is not a qualifying load.
REQ-020 Load-use hazard = id_valid & a used source index !=0 & equal to the EX qualifying load rd or any valid scoreboard entry rd.
REQ-021 Load-use hazard (combinational) -> stall_pc=1, stall_if_id=1, flush_id_ex=1 in the same cycle.
REQ-022 ex_branch_taken -> flush_if_id=1, flush_id_ex=1, stall_pc=0, stall_if_id=0; overrides load-use hazard and ecall.
REQ-023 Halt FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-024 RUN -> DRAIN when id_valid & id_ecall & !ex_branch_taken & no load-use hazard; drain counter loads DRAIN.
REQ-025 DRAIN: stall_pc=1, stall_if_id=1, flush_id_ex=1; counter decrements each cycle; at counter==1 next state HALTED.
REQ-026 HALTED: halt=1, stall_pc=1, stall_if_id=1, flush_id_ex=1; exits only by reset.
REQ-027 ex_branch_taken during DRAIN or HALTED is ignored (cannot occur legally; no outputs change).
REQ-028 In RUN with neither hazard nor redirect, all stall/flush outputs 0.
REQ-029 stall_cnt increments by 1 every cycle stall_pc=1; flush_cnt increments by 1 every cycle ex_branch_taken=1 in RUN.
REQ-030 Counters saturate at all-ones; no wrap.
REQ-031 x0 (index 0) never causes a hazard.

Reset
REQ-032 rst low asynchronously clears scoreboard valids, drain counter, counters to 0, FSM to RUN, halt to 0.
REQ-033 Reset asserted mid-DRAIN or in HALTED returns to RUN; halt falls while rst is low, without waiting for clk.
REQ-034 Outputs remain at reset values until the first rising clk edge after rst deasserts.

Verification
REQ-035 LD_LAT=1: EX load rd=5, ID uses rs1=5 -> one cycle stall_pc=stall_if_id=flush_id_ex=1, next cycle all 0; stall_cnt=1.
REQ-036 LD_LAT=3: load rd=7 then ID reads x7 each cycle -> stall asserted 3 consecutive cycles, then released.
REQ-037 Load-use hazard and ex_branch_taken same cycle -> flush_if_id=flush_id_ex=1, stall_pc=0; flush_cnt=1, stall_cnt=0.
REQ-038 ID ecall, DRAIN=3 -> DRAIN for 3 cycles, halt=1 on 4th cycle and stays high for 100 cycles.
REQ-039 Load rd=0, ID reads x0 -> no stall.
REQ-040 rst low during DRAIN -> halt=0, state RUN immediately; CNT_W=4, 20 stall cycles -> stall_cnt=15.
